// File: rtl/burst_write_master.sv
// Avalon-MM burst write master: moves ctrl_length stream words to memory in bursts of up to BURST_COUNT.
// Optional macro BURST_WRITE_PATTERN_EN adds ctrl_pattern (incrementing-counter fill instead of st_data).
// Latency: a burst starts 1 cycle after its data is buffered; one idle write cycle separates bursts.
// Backpressure: st_ready drops when the FIFO is full or all words are taken; waitrequest holds the beat.
module burst_write_master #(
  parameter int ADDRESS_WIDTH          = 32,
  parameter int DATA_WIDTH             = 32,
  parameter int BYTE_ENABLE_WIDTH      = 4,
  parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
  parameter int LENGTH_WIDTH           = 32,
  parameter int BURST_COUNT            = 8,
  parameter int BURST_WIDTH            = 4,
  parameter int FIFO_DEPTH             = 32,
  parameter int FIFO_DEPTH_LOG2        = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_write,
  output logic [DATA_WIDTH-1:0]        master_writedata,
  output logic [BURST_WIDTH-1:0]       master_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
  input  logic                         master_waitrequest,
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]      ctrl_length,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
`ifdef BURST_WRITE_PATTERN_EN
  input  logic                         ctrl_pattern,
`endif
  input  logic [DATA_WIDTH-1:0]        st_data,
  input  logic                         st_valid,
  output logic                         st_ready
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST} state_t;

  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [ADDRESS_WIDTH-1:0]   ADDR_MASK = ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH - 1);
  localparam logic [LENGTH_WIDTH-1:0]    LEN_ONE   = LENGTH_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0]     BURST_ONE = BURST_WIDTH'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);
  localparam logic [CW-1:0]              CNT_ONE   = CW'(1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LENGTH_WIDTH-1:0]  length_q, length_d;
  logic [LENGTH_WIDTH-1:0]  accepted_q, accepted_d;
  logic [BURST_WIDTH-1:0]   burstcount_q, burstcount_d;
  logic [BURST_WIDTH-1:0]   beats_q, beats_d;
  logic                     write_q, write_d;
  logic                     done_q, done_d;

  logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              fifo_count_q;
  logic                       fifo_full;

  logic [BURST_WIDTH-1:0] bsize;
  logic                   fill_ok;
  logic                   push, pop, start_acc;
  logic [DATA_WIDTH-1:0]  push_dat;

  assign ctrl_busy         = (state_q != IDLE);
  assign ctrl_done         = done_q;
  assign master_address    = addr_q;
  assign master_write      = write_q;
  assign master_burstcount = burstcount_q;
  assign master_byteenable = '1;
  assign master_writedata  = fifo_mem[rd_ptr_q];

  assign fifo_full = (fifo_count_q == CW'(FIFO_DEPTH));
  assign bsize     = (remaining_q >= LENGTH_WIDTH'(BURST_COUNT)) ? BURST_WIDTH'(BURST_COUNT)
                                                                 : remaining_q[BURST_WIDTH-1:0];
  assign fill_ok   = ctrl_busy && !fifo_full && (accepted_q < length_q);
  assign pop       = write_q && !master_waitrequest;
  assign start_acc = (state_q == IDLE) && ctrl_start && !done_q && (ctrl_length != '0);

`ifdef BURST_WRITE_PATTERN_EN
  logic pattern_q;

  // The accepted count doubles as the generator value, so pattern words run 0,1,2,...
  assign st_ready = fill_ok && !pattern_q;
  assign push     = pattern_q ? fill_ok : (st_valid && fill_ok);
  assign push_dat = pattern_q ? DATA_WIDTH'(accepted_q) : st_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= 1'b0;
    end else if (start_acc) begin
      pattern_q <= ctrl_pattern;
    end
  end
`else
  assign st_ready = fill_ok;
  assign push     = st_valid && fill_ok;
  assign push_dat = st_data;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_ONE;
        2'b01:   fifo_count_q <= fifo_count_q - CNT_ONE;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    length_d     = length_q;
    accepted_d   = push ? (accepted_q + LEN_ONE) : accepted_q;
    burstcount_d = burstcount_q;
    beats_d      = beats_q;
    write_d      = write_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped on purpose.
        if (ctrl_start && !done_q) begin
          if (ctrl_length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = WAIT_DATA;
            addr_d      = ctrl_baseaddress & ~ADDR_MASK;
            remaining_d = ctrl_length;
            length_d    = ctrl_length;
            accepted_d  = '0;
          end
        end
      end
      WAIT_DATA: begin
        if (fifo_count_q >= CW'(bsize)) begin
          write_d      = 1'b1;
          burstcount_d = bsize;
          beats_d      = bsize;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          beats_d = beats_q - BURST_ONE;
          if (beats_q == BURST_ONE) begin
            write_d     = 1'b0;
            remaining_d = remaining_q - LENGTH_WIDTH'(burstcount_q);
            addr_d      = addr_q + (ADDRESS_WIDTH'(burstcount_q) << BYTE_ENABLE_WIDTH_LOG2);
            if (remaining_q == LENGTH_WIDTH'(burstcount_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT_DATA;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      length_q     <= '0;
      accepted_q   <= '0;
      burstcount_q <= '0;
      beats_q      <= '0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      length_q     <= length_d;
      accepted_q   <= accepted_d;
      burstcount_q <= burstcount_d;
      beats_q      <= beats_d;
      write_q      <= write_d;
      done_q       <= done_d;
    end
  end

endmodule
